// File: rtl/subtrator_serial_if.sv
// subtrator_serial_if: operand/start, result/status and display bundle; OP exists only with SERIAL_ADD_MODE_EN
interface subtrator_serial_if #(parameter int N = 4);
  logic         START;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         BE;
`ifdef SERIAL_ADD_MODE_EN
  logic         OP;
`endif
  logic [N-1:0] R;
  logic         BS;
  logic         BUSY;
  logic         DONE;
  logic [0:6]   HEX0;
  logic [0:6]   HEX1;
`ifdef SERIAL_ADD_MODE_EN
  modport master (output START, A, B, BE, OP, input R, BS, BUSY, DONE, HEX0, HEX1);
  modport slave  (input START, A, B, BE, OP, output R, BS, BUSY, DONE, HEX0, HEX1);
`else
  modport master (output START, A, B, BE, input R, BS, BUSY, DONE, HEX0, HEX1);
  modport slave  (input START, A, B, BE, output R, BS, BUSY, DONE, HEX0, HEX1);
`endif
endinterface

// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial LSB-first N-bit subtractor with 7-segment result display
// Defining SERIAL_ADD_MODE_EN adds a latched OP input selecting addition when 1.
module subtrator_serial #(parameter int N = 4) (
  input logic CLOCK_50,
  input logic KEY0,
  subtrator_serial_if.slave io
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIM} state_t;
  state_t       state_q, state_d;
  logic [N-1:0] sa_q, sa_d, sb_q, sb_d, acc_q, acc_d, r_q, r_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         bf_q, bf_d, bs_q, bs_d, busy_q, busy_d, done_q, done_d;
  logic         op_q, op_d;
  logic         d, bo, last;
  logic [N:0]   acc_w;
  logic [3:0]   nib;
  always_comb begin
    d     = sa_q[0] ^ sb_q[0] ^ bf_q;
    bo    = op_q ? (sa_q[0] & sb_q[0]) | (sa_q[0] & bf_q) | (sb_q[0] & bf_q)
                 : (~sa_q[0] & sb_q[0]) | (~sa_q[0] & bf_q) | (sb_q[0] & bf_q);
    acc_w = {d, acc_q};
    last  = cnt_q == 5'(N - 1);
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    bf_d    = bf_q;
    bs_d    = bs_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (io.START) begin
        sa_d    = io.A;
        sb_d    = io.B;
        bf_d    = io.BE;
`ifdef SERIAL_ADD_MODE_EN
        op_d    = io.OP;
`else
        op_d    = 1'b0;
`endif
        acc_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = acc_w[N:1];
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bf_d  = bo;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          r_d     = acc_w[N:1];
          bs_d    = bo;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIM;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      bf_q    <= 1'b0;
      bs_q    <= 1'b0;
      op_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      bf_q    <= bf_d;
      bs_q    <= bs_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  function automatic logic [0:6] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction
  always_comb nib = 4'(r_q);
  assign io.R    = r_q;
  assign io.BS   = bs_q;
  assign io.BUSY = busy_q;
  assign io.DONE = done_q;
  assign io.HEX0 = seg(nib);
  assign io.HEX1 = bs_q ? 7'b1001111 : 7'b0000001;
endmodule

// File: doc/subtrator_serial.md
Name: subtrator_serial

Overview:
- Bit-serial N-bit subtractor: the inverse of the team's combinational 1-bit adder.
- Operands are latched on a start request. One full-subtractor step runs per clock, LSB first, with the borrow held in a flip-flop.
- The result is captured on completion and shown on two active-low 7-segment displays: result low nibble and borrow-out flag.
- Sits on the DE-board lab top level; fed from switches, displayed on HEX0/HEX1.

Parameters:
N, 4, operand/result width in bits (legal range 1..16)

Ports:
CLOCK_50  input  1  system clock; all state changes on its rising edge
KEY0  input  1  reset, asynchronous, active-low
START  input  1  start request, sampled only in IDLE
A  input  N  minuend
B  input  N  subtrahend
BE  input  1  borrow-in, latched with the operands
R  output  N  registered difference A-B-BE, modulo 2^N
BS  output  1  registered borrow-out of the MSB step
BUSY  output  1  high while bits are being processed
DONE  output  1  one-cycle pulse when R/BS are updated
HEX0  output  [0:6]  active-low segments a..g, hex glyph of R[3:0] (zero-extended when N<4)
HEX1  output  [0:6]  active-low segments, glyph "1" if BS=1, else "0"

Behaviour:
- Reset (KEY0=0, asynchronous, any state including mid-operation):
  - state=IDLE; R=0, BS=0, BUSY=0, DONE=0.
  - Operand shift registers, borrow FF and bit counter cleared.
  - HEX0 shows "0" (0000001), HEX1 shows "0".
- States: IDLE, SHIFT, FIM.
- IDLE: on an edge with START=1, load shift regs SA<=A, SB<=B, borrow FF<=BE, cnt<=0; go to SHIFT. START=0 stays in IDLE.
- SHIFT (BUSY=1), each edge:
  - Compute d = SA[0]^SB[0]^bf and bo = (~SA[0]&SB[0]) | (~SA[0]&bf) | (SB[0]&bf).
  - Shift the result accumulator right, inserting d at the MSB.
  - Shift SA and SB right (zero fill); bf<=bo; cnt<=cnt+1.
  - On the edge where cnt==N-1: R<=final accumulator (including this bit), BS<=bo, go to FIM.
- FIM: DONE=1 for exactly this cycle, BUSY=0; next edge goes to IDLE unconditionally. START during FIM is ignored.
- Latency: START sampled at edge k; R/BS valid after edge k+N; DONE high during cycle k+N to k+N+1.
- START is ignored while in SHIFT or FIM; there is no queuing. A and B may change freely after the load edge.
- R and BS hold their value until the next completion; intermediate bits are never visible on R.
- N=1: a single SHIFT edge, then FIM.
- Segment decode is combinational from R/BS, active-low, bit 0=a … bit 6=g. Standard hex glyphs 0-9, A, b, C, d, E, F.

Optional Feature:
- Macro: SERIAL_ADD_MODE_EN.
- When defined:
  - Extra input OP (1 bit) is latched with the operands; OP=1 selects addition.
  - Addition step: d = a^b^c, c_out = (a&b)|(a&c)|(b&c), with BE acting as carry-in and BS reporting carry-out.
  - OP=0 behaves exactly as subtraction.
- When undefined: no OP port; subtraction only.

Test Plan:
- Reset, then A=9, B=3, BE=0, START one cycle → BUSY high 4 cycles, DONE pulse 4 edges after start edge, R=6, BS=0, HEX0=0100000, HEX1=0000001.
- A=3, B=5, BE=0 → R=14, BS=1, HEX0=0110000 ("E"), HEX1=1001111 ("1").
- A=0, B=0, BE=1 → R=15, BS=1, HEX0=0111000 ("F").
- START re-asserted every cycle during SHIFT with new A/B → original result unchanged; exactly one DONE per accepted start; next start accepted only from IDLE.
- KEY0 pulsed low after 2 shift edges → R=0, BS=0, BUSY=0, DONE never pulses; a following start computes correctly.
- With SERIAL_ADD_MODE_EN: OP=1, A=9, B=8, BE=0 → R=1, BS=1, HEX0=1001111; OP=0 same operands → R=1, BS=0.
